vic_ctrl: RTL and testbench
===========================

# vic_ctrl

Vectored interrupt controller for the 8-bit non-pipelined processor. It latches edge-triggered interrupt requests and applies a programmable enable mask. It arbitrates the requests by fixed priority and runs the intr/inta handshake with the core, handing over a 4-bit vector that the core loads into its 4-bit PC. It sits beside the core in the top-level, between the external request lines and the core's interrupt inputs, and holds one in-service interrupt until end-of-interrupt.

## Interface
- N_IRQ, 4, number of request lines; index 0 is highest priority
- VEC_W, 4, vector width; equals the PC width
- VEC_BASE, 4'hC, vector for irq 0; vector = VEC_BASE + id, modulo 2^VEC_W
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- irq  in  N_IRQ  external requests; a rising edge is an event
- mask_we  in  1  write strobe for the mask register
- mask_wdata  in  N_IRQ  new mask; 1 = line enabled
- ien  in  1  global interrupt enable from the core
- intr  out  1  interrupt request to the core
- inta  in  1  acknowledge from the core; one-cycle pulse
- vec_valid  out  1  vec is valid; one-cycle pulse
- vec  out  VEC_W  vector of the acknowledged line
- eoi  in  1  end-of-interrupt from the core; one-cycle pulse
- pending  out  N_IRQ  latched, unserviced events
- in_service  out  N_IRQ  one-hot line under service, or 0

## Operation
- Reset values:
  - intr=0, vec_valid=0, vec=0, pending=0, in_service=0, mask=0
  - edge-detect register irq_d = all ones, so a level held high through reset does not fire
  - state = IDLE
- Edge detect:
  - pending[i] is set when irq[i] & ~irq_d[i]; irq_d <= irq every cycle
  - the mask does not gate the latching step; it gates arbitration only
- cand = pending & mask. winner = lowest set index of cand.
- mask_we loads the mask at the clock edge. Arbitration in that same cycle uses the old mask.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if ien && cand!=0, go to REQ; intr becomes 1.
  - REQ: intr held at 1. Winner is re-evaluated every cycle, so a higher-priority arrival before inta wins.
    - On inta: latch winner and set vec = VEC_BASE+winner. Pulse vec_valid. Clear pending[winner], set in_service[winner]. Go to SERVICE; intr becomes 0 on the same edge.
    - Else if cand==0 or ien==0: go to IDLE; intr becomes 0.
    - inta takes precedence over the ien/cand exit when both occur in the same cycle.
  - SERVICE: intr=0, no nesting. On eoi: clear in_service and go to IDLE.
- Ignored inputs:
  - inta outside REQ
  - eoi outside SERVICE
- Simultaneous set and clear of the same pending bit (a new edge on the line being acknowledged): set wins, and the bit stays 1.
- Edges that arrive during SERVICE are latched and served after eoi, highest priority first.
- rst asserted in any state: all state returns to reset values at that edge, and any in-flight handshake is abandoned.

## Timing
- Edge on irq[i] sampled at edge k → pending[i]=1 after k → intr=1 after k+1. This is 2 cycles from the first sampled high, given IDLE, ien=1 and the line enabled.
- inta sampled at edge m → vec_valid=1 and vec valid after m, for exactly one cycle. intr=0 after m.
- eoi sampled at edge n → state=IDLE after n. A waiting candidate raises intr after n+1.
- Back-to-back pulses: a second rising edge needs irq low for at least one sampled cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package / header vic_pkg:
  - state encodings: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2
  - default N_IRQ, VEC_W and VEC_BASE constants
- Sub-module vic_prio_enc: combinational fixed-priority encoder, cand[N_IRQ-1:0] → {any, id}. It is reused for the winner calculation.
- The top-level adds the vic_ctrl instance. The core's vectored-fetch logic loads vec into pc on vec_valid.

## Test plan
- Reset with irq=4'b1111 held, mask=4'b1111, ien=1 → no pending bits and intr stays 0. Drop irq[2], then raise it → pending=4'b0100, intr=1 two cycles later.
- Raise irq 3 and 1 together, then inta → vec=4'hD (line 1), in_service=4'b0010, pending=4'b1000. After eoi → intr reasserts. Second inta → vec=4'hF.
- In REQ for line 3, raise irq 0 before inta → inta returns vec=4'hC, and line 3 stays pending.
- Line 2 pending, then write mask=0 while in REQ → intr falls the next cycle and pending[2] is retained. Write mask=4'b0100 → intr rises again.
- During SERVICE of line 1, raise irq 1 again and pulse a spurious inta → no vec_valid, pending[1]=1. After eoi → a new request for vec=4'hD.
- Assert rst in SERVICE → in_service=0, pending=0, intr=0. A following eoi has no effect.

Source files
------------

// File: rtl/vic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vic_pkg
//  Brief    : Shared constants and state encoding for the vectored interrupt
//             controller (vic_ctrl / vic_prio_enc).
//  Revision : 1.0 - initial release
// ============================================================================
package vic_pkg;

  // Default build-time configuration
  localparam int         N_IRQ_DEF    = 4;
  localparam int         VEC_W_DEF    = 4;
  localparam logic [3:0] VEC_BASE_DEF = 4'hC;

  // Handshake state encoding (explicit 2-bit width)
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } vic_state_t;

endpackage
`default_nettype wire

// File: rtl/vic_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : vic_prio_enc
//  Brief    : Combinational fixed-priority encoder. Index 0 is the highest
//             priority; returns whether any bit is set and the lowest set index.
//  Revision : 1.0 - initial release
// ============================================================================
module vic_prio_enc #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    cand,
  output logic            any,
  output logic [ID_W-1:0] id
);

  // Scan from the lowest-priority end so the lowest set index is written last
  always_comb begin
    any = 1'b0;
    id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        any = 1'b1;
        id  = ID_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vic_ctrl
//  Brief    : Vectored interrupt controller. Latches rising edges on the
//             request lines, masks them, arbitrates by fixed priority and runs
//             the intr/inta/eoi handshake with the core, handing over a vector
//             of VEC_BASE + id. One interrupt in service at a time, no nesting.
//  Revision : 1.0 - initial release
// ============================================================================
module vic_ctrl
  import vic_pkg::*;
#(
  parameter int               N_IRQ    = N_IRQ_DEF,
  parameter int               VEC_W    = VEC_W_DEF,
  parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(VEC_BASE_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             ien,
  output logic             intr,
  input  logic             inta,
  output logic             vec_valid,
  output logic [VEC_W-1:0] vec,
  input  logic             eoi,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service
);

  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  vic_state_t       r_state;
  vic_state_t       w_state_nxt;
  logic [N_IRQ-1:0] r_irq_d;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_in_service;
  logic             r_intr;
  logic             r_vec_valid;
  logic [VEC_W-1:0] r_vec;

  logic [N_IRQ-1:0] w_cand;
  logic             w_any;
  logic [ID_W-1:0]  w_id;
  logic [N_IRQ-1:0] w_win_oh;
  logic [N_IRQ-1:0] w_edge;
  logic             w_ack;
  logic             w_eoi_ok;

  // The mask only gates arbitration; latching ignores it. A mask write lands
  // at the clock edge, so this cycle's arbitration still sees the old mask.
  assign w_cand   = r_pending & r_mask;
  assign w_win_oh = N_IRQ'(1) << w_id;
  assign w_edge   = irq & ~r_irq_d;

  vic_prio_enc #(
    .N    (N_IRQ),
    .ID_W (ID_W)
  ) u_prio_enc (
    .cand (w_cand),
    .any  (w_any),
    .id   (w_id)
  );

  // Next-state decode for the intr/inta/eoi handshake
  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_eoi_ok    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ien && w_any) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        // inta beats the ien/cand exit; an inta with no candidate left
        // (mask just cleared) has nothing to hand over and simply exits.
        if (inta && w_any) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_SERVICE;
        end else if (!w_any || !ien) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          w_eoi_ok    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_intr      <= 1'b0;
      r_vec_valid <= 1'b0;
      r_vec       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_intr      <= (w_state_nxt == ST_REQ);
      r_vec_valid <= w_ack;
      if (w_ack) begin
        r_vec <= VEC_BASE + VEC_W'(w_id);
      end
    end
  end

  // Edge capture into pending; a new edge on the line being acknowledged wins
  // over the acknowledge clear. irq_d resets high so a held level is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_d   <= '1;
      r_pending <= '0;
    end else begin
      r_irq_d   <= irq;
      r_pending <= (r_pending & ~(w_ack ? w_win_oh : '0)) | w_edge;
    end
  end

  // Programmable enable mask
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
    end else if (mask_we) begin
      r_mask <= mask_wdata;
    end
  end

  // One-hot in-service tracking between acknowledge and end-of-interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_service <= '0;
    end else if (w_ack) begin
      r_in_service <= w_win_oh;
    end else if (w_eoi_ok) begin
      r_in_service <= '0;
    end
  end

  assign intr       = r_intr;
  assign vec_valid  = r_vec_valid;
  assign vec        = r_vec;
  assign pending    = r_pending;
  assign in_service = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_vic_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vic_ctrl
//  Brief    : Self-checking bench for vic_ctrl: directed handshake scenarios
//             followed by randomized traffic against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vic_ctrl;

  localparam int N_IRQ = 4;

  logic             clk;
  logic             rst;
  logic [N_IRQ-1:0] irq;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             ien;
  logic             intr;
  logic             inta;
  logic             vec_valid;
  logic [3:0]       vec;
  logic             eoi;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] in_service;

  int n_cmp;
  int n_bad;

  // Behavioural model: pending set, mask, previous irq sample, a flag for
  // "asking the core", and the id being serviced (-1 when none).
  logic [3:0] m_pend;
  logic [3:0] m_mask;
  logic [3:0] m_prev;
  bit         m_asking;
  int         m_svc;
  bit         m_vv;
  logic [3:0] m_vec;

  vic_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ien        (ien),
    .intr       (intr),
    .inta       (inta),
    .vec_valid  (vec_valid),
    .vec        (vec),
    .eoi        (eoi),
    .pending    (pending),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the spec's rules to the inputs seen at this clock edge
  task automatic model_update();
    int         win;
    logic [3:0] cand;
    logic [3:0] clr;
    if (rst) begin
      m_pend = 4'h0; m_mask = 4'h0; m_prev = 4'hF;
      m_asking = 0; m_svc = -1; m_vv = 0; m_vec = 4'h0;
      return;
    end
    cand = m_pend & m_mask;
    win  = -1;
    for (int i = 0; i < N_IRQ; i++) if (cand[i] && win < 0) win = i;
    clr  = 4'h0;
    m_vv = 0;
    if (m_svc >= 0) begin
      if (eoi) m_svc = -1;
    end else if (m_asking) begin
      if (inta && win >= 0) begin
        m_vv     = 1;
        m_vec    = 4'((12 + win) % 16);
        m_svc    = win;
        clr[win] = 1'b1;
        m_asking = 0;
      end else if (win < 0 || !ien) begin
        m_asking = 0;
      end
    end else if (ien && win >= 0) begin
      m_asking = 1;
    end
    m_pend = (m_pend & ~clr) | (irq & ~m_prev);
    m_prev = irq;
    if (mask_we) m_mask = mask_wdata;
  endtask

  // One clock: edge, model update, compare all outputs, then drop pulse inputs
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("intr",       32'(intr),       32'(m_asking));
    check("vec_valid",  32'(vec_valid),  32'(m_vv));
    check("vec",        32'(vec),        32'(m_vec));
    check("pending",    32'(pending),    32'(m_pend));
    check("in_service", 32'(in_service), (m_svc < 0) ? 32'd0 : (32'd1 << m_svc));
    rst = 0; inta = 0; eoi = 0; mask_we = 0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1; irq = 4'hF; mask_we = 0; mask_wdata = 4'h0; ien = 1; inta = 0; eoi = 0;
    m_pend = 4'h0; m_mask = 4'h0; m_prev = 4'hF; m_asking = 0; m_svc = -1; m_vv = 0; m_vec = 4'h0;
    #2;

    // Reset with all lines held high: nothing fires
    step();
    check("rst_pending", 32'(pending), 32'h0);
    mask_we = 1; mask_wdata = 4'hF;
    step(); step(); step();
    check("held_no_intr", 32'(intr), 32'h0);
    check("held_no_pend", 32'(pending), 32'h0);

    // Drop and raise irq[2]
    irq = 4'b1011; step();
    irq = 4'b1111; step();
    check("pend_l2", 32'(pending), 32'h4);
    step();
    check("intr_l2", 32'(intr), 32'h1);
    inta = 1; step();
    check("vec_l2", 32'(vec), 32'hE);
    eoi = 1; step();

    // Lines 3 and 1 together: line 1 first, then line 3
    irq = 4'b0000; step();
    irq = 4'b1010; step(); step();
    inta = 1; step();
    check("vec_l1", 32'(vec), 32'hD);
    check("isvc_l1", 32'(in_service), 32'h2);
    check("pend_l3", 32'(pending), 32'h8);
    eoi = 1; step();
    step();
    check("intr_again", 32'(intr), 32'h1);
    inta = 1; step();
    check("vec_l3", 32'(vec), 32'hF);
    eoi = 1; step();

    // Randomized traffic, model-checked every cycle
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N_IRQ; b++)
        if ($urandom_range(7) == 0) irq[b] = ~irq[b];
      if ($urandom_range(15) == 0) begin
        mask_we = 1; mask_wdata = 4'($urandom_range(15));
      end
      ien  = ($urandom_range(9) != 0);
      inta = m_asking ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
      eoi  = (m_svc >= 0) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      rst  = ($urandom_range(199) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
